// File: rtl/hwpe_stream_serialize_mc_pkg.sv
// Shared control/flag types for the multi-channel serializer.
package hwpe_stream_serialize_mc_pkg;

  localparam int unsigned HWPE_STREAM_SER_MC_MAX_STREAMS = 16;
  localparam int unsigned HWPE_STREAM_SER_MC_IDX_WIDTH = 4;
  localparam int unsigned HWPE_STREAM_SER_MC_CONTIG_WIDTH = 16;
  localparam int unsigned HWPE_STREAM_SER_MC_CNT_WIDTH = 32;

  // Fields are sized for the largest instance; each instance uses the low bits.
  typedef struct packed {
    logic                                                                     start;
    logic [HWPE_STREAM_SER_MC_MAX_STREAMS-1:0]                                enable_mask;
    logic [HWPE_STREAM_SER_MC_IDX_WIDTH-1:0]                                  first_stream;
    logic [HWPE_STREAM_SER_MC_MAX_STREAMS-1:0][HWPE_STREAM_SER_MC_CONTIG_WIDTH-1:0] nb_contig_m1;
    logic [HWPE_STREAM_SER_MC_CNT_WIDTH-1:0]                                  nb_packets;
  } ctrl_serialize_mc_t;

  typedef struct packed {
    logic                                    busy;
    logic                                    done;
    logic [HWPE_STREAM_SER_MC_IDX_WIDTH-1:0] cur_stream;
    logic [HWPE_STREAM_SER_MC_CNT_WIDTH-1:0] pkt_cnt;
  } flags_serialize_mc_t;

endpackage

// File: rtl/hwpe_stream_serialize_mc_outreg.sv
// One-entry pipeline register with full-throughput ready/valid handshake.
module hwpe_stream_serialize_mc_outreg #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [STRB_WIDTH-1:0] in_strb,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [STRB_WIDTH-1:0] out_strb,
  input  logic                  out_ready
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [STRB_WIDTH-1:0] strb_q;

  // Accept when empty or when the held beat leaves in the same cycle.
  assign in_ready  = ~valid_q | out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_strb  = strb_q;

  // Register load/drain; clear discards any held beat.
  always_ff @(posedge clk_i) begin
    if (rst_i | clear_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      strb_q  <= '0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) begin
        data_q <= in_data;
        strb_q <= in_strb;
      end
    end
  end

endmodule

// File: rtl/hwpe_stream_serialize_mc.sv
// Multi-channel programmable serializer: per-stream bursts, enable mask, bounded jobs.
module hwpe_stream_serialize_mc
  import hwpe_stream_serialize_mc_pkg::*;
#(
  parameter int unsigned NB_IN_STREAMS = 4,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned CONTIG_WIDTH  = 10,
  parameter int unsigned CNT_WIDTH     = 16,
  parameter bit          OUT_REG       = 1'b1
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      clear_i,
  input  ctrl_serialize_mc_t                        ctrl_i,
  output flags_serialize_mc_t                       flags_o,
  input  logic [NB_IN_STREAMS-1:0]                  push_valid_i,
  input  logic [NB_IN_STREAMS-1:0][DATA_WIDTH-1:0]  push_data_i,
  input  logic [NB_IN_STREAMS-1:0][STRB_WIDTH-1:0]  push_strb_i,
  output logic [NB_IN_STREAMS-1:0]                  push_ready_o,
  output logic                                      pop_valid_o,
  output logic [DATA_WIDTH-1:0]                     pop_data_o,
  output logic [STRB_WIDTH-1:0]                     pop_strb_o,
  input  logic                                      pop_ready_i
);

  localparam int unsigned IDX_W = (NB_IN_STREAMS > 1) ? $clog2(NB_IN_STREAMS) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} fsm_state_e;

  // Lowest enabled index at or above 'from', else lowest enabled index overall.
  function automatic logic [IDX_W-1:0] next_enabled(input logic [NB_IN_STREAMS-1:0] mask,
                                                    input int from);
    logic [IDX_W-1:0] res;
    logic             found;
    res   = '0;
    found = 1'b0;
    for (int i = int'(NB_IN_STREAMS) - 1; i >= 0; i--) begin
      if (mask[i] && (i >= from)) begin
        res   = IDX_W'(i);
        found = 1'b1;
      end
    end
    if (!found) begin
      for (int i = int'(NB_IN_STREAMS) - 1; i >= 0; i--) begin
        if (mask[i]) res = IDX_W'(i);
      end
    end
    return res;
  endfunction

  fsm_state_e                                state_q, state_d;
  logic [IDX_W-1:0]                          cur_q, cur_d;
  logic [CONTIG_WIDTH-1:0]                   contig_q, contig_d;
  logic [CNT_WIDTH-1:0]                      pkt_q, pkt_d;
  logic [CNT_WIDTH-1:0]                      nb_pkt_q, nb_pkt_d;
  logic [NB_IN_STREAMS-1:0]                  mask_q, mask_d;
  logic [NB_IN_STREAMS-1:0][CONTIG_WIDTH-1:0] contig_m1_q, contig_m1_d;
  logic                                      busy_q, done_q, done_d;

  logic run, cur_valid, stage_ready, xfer, pop_fire;
  logic unused_ctrl;

  assign run       = (state_q == StRun);
  assign cur_valid = push_valid_i[cur_q];
  assign xfer      = run & cur_valid & stage_ready;
  assign pop_fire  = pop_valid_o & pop_ready_i;
  // Upper bits of the shared-width control fields are intentionally ignored.
  assign unused_ctrl = ^ctrl_i;

  // Only the current stream ever sees ready, and only while running.
  always_comb begin
    push_ready_o        = '0;
    push_ready_o[cur_q] = run & stage_ready;
  end

  if (OUT_REG) begin : gen_out_reg
    logic stage_valid;
    assign stage_valid = run & cur_valid;

    hwpe_stream_serialize_mc_outreg #(
      .DATA_WIDTH(DATA_WIDTH),
      .STRB_WIDTH(STRB_WIDTH)
    ) i_outreg (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clear_i  (clear_i),
      .in_valid (stage_valid),
      .in_data  (push_data_i[cur_q]),
      .in_strb  (push_strb_i[cur_q]),
      .in_ready (stage_ready),
      .out_valid(pop_valid_o),
      .out_data (pop_data_o),
      .out_strb (pop_strb_o),
      .out_ready(pop_ready_i)
    );
  end else begin : gen_pass
    assign stage_ready = pop_ready_i;
    assign pop_valid_o = run & cur_valid;
    assign pop_data_o  = run ? push_data_i[cur_q] : '0;
    assign pop_strb_o  = run ? push_strb_i[cur_q] : '0;
  end

  // Next-state: job latch on start, burst/stream stepping and job termination.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    contig_d    = contig_q;
    pkt_d       = pkt_q;
    nb_pkt_d    = nb_pkt_q;
    mask_d      = mask_q;
    contig_m1_d = contig_m1_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ctrl_i.start && (ctrl_i.enable_mask[NB_IN_STREAMS-1:0] != '0)) begin
          mask_d   = ctrl_i.enable_mask[NB_IN_STREAMS-1:0];
          nb_pkt_d = ctrl_i.nb_packets[CNT_WIDTH-1:0];
          for (int i = 0; i < int'(NB_IN_STREAMS); i++) begin
            contig_m1_d[i] = ctrl_i.nb_contig_m1[i][CONTIG_WIDTH-1:0];
          end
          cur_d    = next_enabled(ctrl_i.enable_mask[NB_IN_STREAMS-1:0],
                                  int'(ctrl_i.first_stream));
          contig_d = '0;
          pkt_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        if (xfer) begin
          // Unbounded jobs saturate the counter instead of wrapping.
          if ((nb_pkt_q != '0) || !(&pkt_q)) pkt_d = pkt_q + CNT_WIDTH'(1);
          if (contig_q == contig_m1_q[cur_q]) begin
            contig_d = '0;
            cur_d    = next_enabled(mask_q, int'(cur_q) + 1);
          end else begin
            contig_d = contig_q + CONTIG_WIDTH'(1);
          end
          if ((nb_pkt_q != '0) && ((pkt_q + CNT_WIDTH'(1)) == nb_pkt_q)) begin
            // With the output register the last beat is still held after acceptance.
            if (OUT_REG) begin
              state_d = StDrain;
            end else begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end
        end
      end
      StDrain: begin
        if (pop_fire) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; reset and clear override any start or handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i | clear_i) begin
      state_q     <= StIdle;
      cur_q       <= '0;
      contig_q    <= '0;
      pkt_q       <= '0;
      nb_pkt_q    <= '0;
      mask_q      <= '0;
      contig_m1_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      contig_q    <= contig_d;
      pkt_q       <= pkt_d;
      nb_pkt_q    <= nb_pkt_d;
      mask_q      <= mask_d;
      contig_m1_q <= contig_m1_d;
      busy_q      <= (state_d != StIdle);
      done_q      <= done_d;
    end
  end

  // Flags zero-extended into the shared-width struct.
  always_comb begin
    flags_o            = '0;
    flags_o.busy       = busy_q;
    flags_o.done       = done_q;
    flags_o.cur_stream = HWPE_STREAM_SER_MC_IDX_WIDTH'(cur_q);
    flags_o.pkt_cnt    = HWPE_STREAM_SER_MC_CNT_WIDTH'(pkt_q);
  end

endmodule

// File: tb/tb_hwpe_stream_serialize_mc.sv
// Scoreboard bench for hwpe_stream_serialize_mc (NB=4, registered output).
module tb_hwpe_stream_serialize_mc;
  import hwpe_stream_serialize_mc_pkg::*;

  localparam int NB = 4;
  localparam int DW = 32;
  localparam int SW = 4;

  logic                       clk;
  logic                       rst, clear;
  ctrl_serialize_mc_t         ctrl;
  flags_serialize_mc_t        flags;
  logic [NB-1:0]              push_valid, push_ready;
  logic [NB-1:0][DW-1:0]      push_data;
  logic [NB-1:0][SW-1:0]      push_strb;
  logic                       pop_valid, pop_ready;
  logic [DW-1:0]              pop_data;
  logic [SW-1:0]              pop_strb;

  int             checks = 0;
  int             errors = 0;
  int             done_pulses = 0;
  int             pop_pct = 100;
  logic [NB-1:0]  hold = '0;
  int unsigned    seq[NB];
  logic [DW+SW-1:0] exp_q[$];

  hwpe_stream_serialize_mc #(
    .NB_IN_STREAMS(NB),
    .DATA_WIDTH   (DW),
    .STRB_WIDTH   (SW),
    .CONTIG_WIDTH (10),
    .CNT_WIDTH    (16),
    .OUT_REG      (1'b1)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (clear),
    .ctrl_i      (ctrl),
    .flags_o     (flags),
    .push_valid_i(push_valid),
    .push_data_i (push_data),
    .push_strb_i (push_strb),
    .push_ready_o(push_ready),
    .pop_valid_o (pop_valid),
    .pop_data_o  (pop_data),
    .pop_strb_o  (pop_strb),
    .pop_ready_i (pop_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] mk_data(input int s, input int unsigned k);
    return {8'(8'hA0 + s), 24'(k)};
  endfunction

  function automatic logic [SW-1:0] mk_strb(input int s, input int unsigned k);
    return 4'(k + 3 * s);
  endfunction

  // Sources and sink: drive on negedge, observe handshakes just before posedge.
  initial begin
    pop_ready  = 1'b0;
    push_valid = '0;
    push_data  = '0;
    push_strb  = '0;
    for (int s = 0; s < NB; s++) seq[s] = 0;
    forever begin
      @(negedge clk);
      pop_ready = (int'($urandom_range(99)) < pop_pct);
      for (int s = 0; s < NB; s++) begin
        push_valid[s] = !hold[s];
        push_data[s]  = mk_data(s, seq[s]);
        push_strb[s]  = mk_strb(s, seq[s]);
      end
      #4;
      for (int s = 0; s < NB; s++) if (push_valid[s] && push_ready[s]) seq[s]++;
      if (flags.done) done_pulses++;
      if (pop_valid && pop_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra_beat: got data %h strb %h, required no beat", pop_data, pop_strb);
        end else begin
          logic [DW+SW-1:0] e;
          e = exp_q.pop_front();
          if ({pop_data, pop_strb} !== e) begin
            errors++;
            $display("FAIL sb_beat: got data %h strb %h, required data %h strb %h",
                     pop_data, pop_strb, e[DW+SW-1:SW], e[SW-1:0]);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Computes the expected beat order independently, then pulses start.
  task automatic start_job(input logic [NB-1:0] mask, input int first, input int c0, input int c1,
                           input int c2, input int c3, input int n, input int model_n);
    int cm[NB];
    int cnt[NB];
    int cur;
    int c;
    cm = '{c0, c1, c2, c3};
    for (int s = 0; s < NB; s++) cnt[s] = int'(seq[s]);
    if (model_n > 0) begin
      cur = (first >= NB) ? 0 : first;
      while (!mask[cur]) cur = (cur + 1) % NB;
      c = 0;
      for (int p = 0; p < model_n; p++) begin
        exp_q.push_back({mk_data(cur, cnt[cur]), mk_strb(cur, cnt[cur])});
        cnt[cur]++;
        c++;
        if (c > cm[cur]) begin
          c = 0;
          cur = (cur + 1) % NB;
          while (!mask[cur]) cur = (cur + 1) % NB;
        end
      end
    end
    @(negedge clk);
    ctrl              = '0;
    ctrl.start        = 1'b1;
    ctrl.enable_mask  = 16'(mask);
    ctrl.first_stream = 4'(first);
    for (int s = 0; s < NB; s++) ctrl.nb_contig_m1[s] = 16'(cm[s]);
    ctrl.nb_packets   = 32'(n);
    @(negedge clk);
    ctrl.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (flags.done) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done: no done pulse within %0d cycles", name, budget);
    end else begin
      checks++;
      if (flags.busy !== 1'b0) begin
        errors++;
        $display("FAIL %s_busy_at_done: got %0b required 0", name, flags.busy);
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    clear = 1'b0;
    ctrl  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (pop_valid !== 1'b0) begin
      errors++; $display("FAIL reset_pop_valid: got %0b required 0", pop_valid);
    end
    checks++;
    if ({pop_data, pop_strb} !== '0) begin
      errors++; $display("FAIL reset_pop_data: got %h/%h required 0", pop_data, pop_strb);
    end
    checks++;
    if (push_ready !== '0) begin
      errors++; $display("FAIL reset_push_ready: got %b required 0", push_ready);
    end
    checks++;
    if (flags.busy !== 1'b0 || flags.done !== 1'b0) begin
      errors++; $display("FAIL reset_busy_done: got %0b/%0b required 0/0", flags.busy, flags.done);
    end
    checks++;
    if (flags.cur_stream !== '0 || flags.pkt_cnt !== '0) begin
      errors++;
      $display("FAIL reset_cur_pkt: got %0d/%0d required 0/0", flags.cur_stream, flags.pkt_cnt);
    end
  endtask

  task automatic test_round_robin();
    pop_pct     = 100;
    done_pulses = 0;
    start_job(4'b1111, 0, 0, 0, 0, 0, 8, 8);
    checks++;
    if (flags.busy !== 1'b1) begin
      errors++; $display("FAIL rr_busy_rise: got %0b required 1", flags.busy);
    end
    wait_done("rr", 50);
    repeat (4) @(negedge clk);
    checks++;
    if (done_pulses != 1) begin
      errors++; $display("FAIL rr_done_pulses: got %0d required 1", done_pulses);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rr_beats_left: got %0d required 0", exp_q.size());
    end
    checks++;
    if (flags.pkt_cnt !== 32'd8) begin
      errors++; $display("FAIL rr_pkt_cnt: got %0d required 8", flags.pkt_cnt);
    end
  endtask

  task automatic test_masked();
    start_job(4'b1010, 0, 0, 2, 0, 0, 8, 8);
    checks++;
    if (flags.cur_stream !== 4'd1) begin
      errors++; $display("FAIL mask_first_remap: got %0d required 1", flags.cur_stream);
    end
    wait_done("mask", 50);
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL mask_beats_left: got %0d required 0", exp_q.size());
    end
  endtask

  task automatic test_random_ready();
    pop_pct = 50;
    start_job(4'b1111, 2, 1, 0, 2, 0, 100, 100);
    wait_done("rand", 2000);
    // done must not precede the final pop
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rand_beats_left_at_done: got %0d required 0", exp_q.size());
    end
    checks++;
    if (flags.pkt_cnt !== 32'd100) begin
      errors++; $display("FAIL rand_pkt_cnt: got %0d required 100", flags.pkt_cnt);
    end
    pop_pct = 100;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stall();
    int p;
    bit seen;
    hold[2] = 1'b1;
    start_job(4'b1111, 0, 0, 0, 0, 0, 8, 8);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (flags.cur_stream == 4'd2) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL stall_reach_2: got cur %0d required 2", flags.cur_stream);
    end
    p = int'(flags.pkt_cnt);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (flags.cur_stream !== 4'd2 || int'(flags.pkt_cnt) != p) begin
        errors++;
        $display("FAIL stall_hold: got cur %0d pkt %0d required cur 2 pkt %0d",
                 flags.cur_stream, flags.pkt_cnt, p);
      end
    end
    hold[2] = 1'b0;
    wait_done("stall", 100);
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL stall_beats_left: got %0d required 0", exp_q.size());
    end
  endtask

  task automatic test_clear();
    pop_pct = 0;
    start_job(4'b1111, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (pop_valid !== 1'b1 || flags.busy !== 1'b1 || flags.pkt_cnt !== 32'd1) begin
      errors++;
      $display("FAIL clear_pre: got valid %0b busy %0b pkt %0d required 1 1 1",
               pop_valid, flags.busy, flags.pkt_cnt);
    end
    clear = 1'b1;
    exp_q.delete();
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if (pop_valid !== 1'b0 || flags.busy !== 1'b0 || flags.pkt_cnt !== '0) begin
      errors++;
      $display("FAIL clear_post: got valid %0b busy %0b pkt %0d required 0 0 0",
               pop_valid, flags.busy, flags.pkt_cnt);
    end
    checks++;
    if (push_ready !== '0) begin
      errors++; $display("FAIL clear_push_ready: got %b required 0", push_ready);
    end
    pop_pct = 100;
    start_job(4'b1111, 3, 0, 0, 0, 0, 4, 4);
    checks++;
    if (flags.cur_stream !== 4'd3) begin
      errors++; $display("FAIL clear_restart_cur: got %0d required 3", flags.cur_stream);
    end
    wait_done("clear_restart", 50);
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL clear_beats_left: got %0d required 0", exp_q.size());
    end
  endtask

  task automatic test_ignored_start();
    start_job(4'b0000, 0, 0, 0, 0, 0, 4, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (flags.busy !== 1'b0 || push_ready !== '0) begin
        errors++;
        $display("FAIL ign_zero_mask: got busy %0b ready %b required 0 0", flags.busy, push_ready);
      end
      @(negedge clk);
    end
    start_job(4'b1111, 0, 0, 0, 0, 0, 12, 12);
    repeat (3) @(negedge clk);
    ctrl.enable_mask  = 16'h0001;
    ctrl.first_stream = 4'd2;
    ctrl.nb_packets   = 32'd2;
    ctrl.nb_contig_m1[0] = 16'd5;
    ctrl.start        = 1'b1;
    @(negedge clk);
    ctrl.start = 1'b0;
    checks++;
    if (flags.busy !== 1'b1) begin
      errors++; $display("FAIL ign_busy_run: got %0b required 1", flags.busy);
    end
    wait_done("ign", 60);
    repeat (2) @(negedge clk);
    checks++;
    if (flags.pkt_cnt !== 32'd12 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ign_job_unchanged: got pkt %0d left %0d required 12 0",
               flags.pkt_cnt, exp_q.size());
    end
  endtask

  initial begin
    rst   = 1'b1;
    clear = 1'b0;
    ctrl  = '0;
    test_reset();
    test_round_robin();
    test_masked();
    test_random_ready();
    test_stall();
    test_clear();
    test_ignored_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
